imem_loader: RTL

//  Writer side of the instruction memory: receives a program as a byte stream over a

---
 rtl/imem_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for instruction memory.
// Optional checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int MAX_WORDS = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  restart,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rstn,
  output logic                  done,
  output logic                  error
);

  localparam int IW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_LEN   = 3'd0,
    S_DATA  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    S_CSUM  = 3'd5
`endif
  } state_t;

  state_t state, state_n;

  logic [1:0]    bcnt;
  logic [IW-1:0] widx;
  logic [IW-1:0] cnt;
  logic [23:0]   shreg;
  logic [31:0]   word_n;
  logic [IW-1:0] widx_inc;
  logic          acc;
  logic          last_b;
  logic          last_w;
  logic          len_big;
  logic          rst_go;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xacc;
`endif

  assign acc      = in_valid & in_ready;
  assign last_b   = (bcnt == 2'd3);
  assign word_n   = {in_data, shreg};
  assign widx_inc = widx + 1'b1;
  assign last_w   = (widx_inc == cnt);
  assign len_big  = (word_n > 32'(MAX_WORDS));
  assign rst_go   = restart &
                    ((state == S_DONE) |
                     (state == S_ERR));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_LEN;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    unique case (state)
      S_LEN: begin
        in_ready = 1'b1;
        if (acc && last_b) begin
          if (word_n == 32'd0)
            state_n = S_DONE;
          else if (len_big)
            state_n = S_ERR;
          else
            state_n = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (acc && last_b)
          state_n = S_WRITE;
      end
      S_WRITE: begin
        if (!last_w)
          state_n = S_DATA;
        else
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_n = S_CSUM;
`else
          state_n = S_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        if (acc)
          state_n = (in_data == xacc) ?
                    S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (restart)
          state_n = S_LEN;
      end
      default: state_n = S_LEN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt       <= '0;
      widx       <= '0;
      cnt        <= '0;
      shreg      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_rstn  <= 1'b0;
    end else if (rst_go) begin
      bcnt       <= '0;
      widx       <= '0;
      cnt        <= '0;
      shreg      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      done       <= 1'b0;
      error      <= 1'b0;
      core_rstn  <= 1'b0;
    end else begin
      imem_we   <= (state == S_DATA) &
                   acc & last_b;
      done      <= (state_n == S_DONE);
      core_rstn <= (state_n == S_DONE);
      error     <= (state_n == S_ERR);
      if (acc) begin
        bcnt  <= bcnt + 1'b1;
        shreg <= word_n[31:8];
      end
      // N fits in IW bits whenever the load proceeds
      if (state == S_LEN && acc && last_b)
        cnt <= word_n[IW-1:0];
      if (state == S_DATA && acc && last_b)
        imem_wdata <= word_n;
      if (state == S_WRITE) begin
        widx      <= widx_inc;
        imem_addr <= imem_addr +
                     ADDR_WIDTH'(4);
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      xacc <= '0;
    else if (rst_go)
      xacc <= '0;
    else if (acc &&
             (state == S_LEN ||
              state == S_DATA))
      xacc <= xacc ^ in_data;
  end
`endif

endmodule
